mcu_subsys_mem_arbiter: RTL

Two-master, one-slave arbiter for the MCU subsystem's valid/ready memory bus. It shares a single memory target (the data-side SRAM) between the CPU data path (master 0, via the host bridge) and a DMA/sample-capture master (master 1). Arbitration is round-robin, and each granted transfer runs until the slave's ready pulse completes it. A watchdog completes stalled transfers with an error word so that neither master can hang the bus.

---
 rtl/mcu_subsys_pkg.sv | 28 ++
 rtl/mcu_subsys_rr_pick2.sv | 16 +
 rtl/mcu_subsys_mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mcu_subsys_pkg.sv
// Shared types and constants for the MCU subsystem memory-bus arbiter.
// Holds the arbiter FSM encoding, the request bundle and the default error word.
package mcu_subsys_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mem_req_t;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   // One-hot grant vector presented for a given arbiter state.
   function automatic logic [1:0] state_grant(arb_state_e s);
      logic [1:0] g;
      g = 2'b00;
      if (s == GRANT0) g = 2'b01;
      if (s == GRANT1) g = 2'b10;
      return g;
   endfunction

endpackage

// File: rtl/mcu_subsys_rr_pick2.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on a tie the master not named by last_grant wins.
module mcu_subsys_rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mcu_subsys_mem_arbiter.sv
// Two-master, one-slave valid/ready memory arbiter with round-robin grant
// and a per-transfer watchdog that completes stalled accesses with an error word.
module mcu_subsys_mem_arbiter
   import mcu_subsys_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        m0_mem_valid,
   output logic        m0_mem_ready,
   input  logic [31:0] m0_mem_addr,
   input  logic [31:0] m0_mem_wdata,
   input  logic [3:0]  m0_mem_wstrb,
   output logic [31:0] m0_mem_rdata,
   input  logic        m1_mem_valid,
   output logic        m1_mem_ready,
   input  logic [31:0] m1_mem_addr,
   input  logic [31:0] m1_mem_wdata,
   input  logic [3:0]  m1_mem_wstrb,
   output logic [31:0] m1_mem_rdata,
   output logic        s_mem_valid,
   input  logic        s_mem_ready,
   output logic [31:0] s_mem_addr,
   output logic [31:0] s_mem_wdata,
   output logic [3:0]  s_mem_wstrb,
   input  logic [31:0] s_mem_rdata,
   output logic        timeout_pulse,
   output logic [7:0]  timeout_count,
   output logic [1:0]  grant_o
);

   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   arb_state_e  state_reg;
   logic        last_grant_reg;
   logic [7:0]  wait_cnt_reg;
   logic [7:0]  timeout_count_reg;

   logic [1:0]  m_valid;
   mem_req_t    m_req [2];
   logic [1:0]  pick_grant;
   logic        in_grant;
   logic        cur_idx;
   logic        cur_valid;
   logic        slave_done;
   logic        timeout_hit;
   mem_req_t    cur_req;
   logic [1:0]  m_ready;
   logic [31:0] m_rdata [2];

   assign m_valid  = {m1_mem_valid, m0_mem_valid};
   assign m_req[0] = '{addr: m0_mem_addr, wdata: m0_mem_wdata, wstrb: m0_mem_wstrb};
   assign m_req[1] = '{addr: m1_mem_addr, wdata: m1_mem_wdata, wstrb: m1_mem_wstrb};

   mcu_subsys_rr_pick2 u_pick (
      .req        (m_valid),
      .last_grant (last_grant_reg),
      .grant      (pick_grant)
   );

   assign in_grant  = (state_reg != IDLE);
   assign cur_idx   = (state_reg == GRANT1);
   assign cur_valid = in_grant && m_valid[cur_idx];

   // Completions are suppressed during reset so a late slave ready is never forwarded.
   assign slave_done  = cur_valid && s_mem_ready && !rst;
   assign timeout_hit = cur_valid && !s_mem_ready && (wait_cnt_reg == WAIT_LIMIT) && !rst;

   assign cur_req     = in_grant ? m_req[cur_idx] : '0;
   assign s_mem_valid = cur_valid && !timeout_hit;
   assign s_mem_addr  = cur_req.addr;
   assign s_mem_wdata = cur_req.wdata;
   assign s_mem_wstrb = cur_req.wstrb;

   for (genvar gi = 0; gi < 2; gi++) begin : g_master
      localparam logic IDX = 1'(gi);
      logic owns;
      assign owns        = in_grant && (cur_idx == IDX);
      assign m_ready[gi] = owns && (slave_done || timeout_hit);
      assign m_rdata[gi] = !owns      ? 32'h0 :
                           slave_done  ? s_mem_rdata :
                           timeout_hit ? ERR_RDATA : 32'h0;
   end

   assign m0_mem_ready  = m_ready[0];
   assign m1_mem_ready  = m_ready[1];
   assign m0_mem_rdata  = m_rdata[0];
   assign m1_mem_rdata  = m_rdata[1];
   assign timeout_pulse = timeout_hit;
   assign timeout_count = timeout_count_reg;
   assign grant_o       = state_grant(state_reg);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         last_grant_reg    <= 1'b1;
         wait_cnt_reg      <= 8'd0;
         timeout_count_reg <= 8'd0;
      end else begin
         if (timeout_hit && (timeout_count_reg != 8'hFF)) begin
            timeout_count_reg <= timeout_count_reg + 8'd1;
         end
         case (state_reg)
            IDLE: begin
               wait_cnt_reg <= 8'd0;
               if (pick_grant[0]) begin
                  state_reg <= GRANT0;
               end else if (pick_grant[1]) begin
                  state_reg <= GRANT1;
               end
            end
            GRANT0, GRANT1: begin
               // A master dropping valid mid-transfer forfeits without touching fairness.
               if (!cur_valid) begin
                  state_reg <= IDLE;
               end else if (slave_done || timeout_hit) begin
                  state_reg      <= IDLE;
                  last_grant_reg <= cur_idx;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
